rfp_i2c_hub: RTL and testbench
==============================

# rfp_i2c_hub

Multi-channel successor to the single-channel RF-power I2C front end. It presents one Wishbone slave to the board bus and routes transactions to NUM_CH `i2c_master_top` byte cores, each driving its own SDA/SCL pair. It also provides:
- a local register page (ID, channel enables, interrupt mask/status, timeout diagnostics);
- registered single-cycle ack/err responses;
- a bus watchdog that converts a hung core access into `wb_err_o` instead of stalling the bus.

## Interface
Parameters:
- NUM_CH, 4, number of I2C channels (1..8)
- TIMEOUT, 255, max cycles in CORE state before error (1..65535)
- ID_VALUE, 32'h52465032, constant returned by ID register ("RFP2")

Ports:
- clk_i  in  1  single system clock; every block register and all cores clock on it
- rst_i  in  1  reset, synchronous, active-high
- wb_cyc_i  in  1  Wishbone cycle
- wb_stb_i  in  1  Wishbone strobe
- wb_we_i  in  1  write enable
- wb_adr_i  in  16  address
- wb_dat_i  in  32  write data
- wb_sel_i  in  4  byte select; ignored, full-word accesses only
- wb_dat_o  out  32  read data, registered
- wb_ack_o  out  1  ack, one-cycle pulse
- wb_err_o  out  1  error, one-cycle pulse
- wb_rty_o  out  1  constant 0
- irq_o  out  1  OR over channels of (core wb_inta_o AND mask bit), registered
- RFP_SDA  inout  NUM_CH  open-drain data, driven 0 when that core's sda_padoen_o=0, else Z
- RFP_SCL  inout  NUM_CH  open-drain clock, same rule using scl_padoen_o

## Operation
Address decode, sampled in IDLE:
- wb_adr_i[15]=0, core page:
  - wb_adr_i[2:0] = core register
  - wb_adr_i[5:3] = channel index
- wb_adr_i[15]=1, local page, selected by wb_adr_i[2:0]:
  - 0 ID, RO = ID_VALUE
  - 1 CTRL, RW:
    - [7:0] channel enable; reset 0
    - [15:8] irq mask; reset 0
    - bits at or above NUM_CH read 0
  - 2 STATUS:
    - [7:0] live core inta, RO
    - [16] sticky timeout flag; write 1 to clear
  - 3 LAST_TO, RO: {13'b0, channel[2:0], adr[15:0]} of the most recent timed-out access
  - 4..7: read 0, writes ignored, ack normally

Core reset:
- Core n receives rst_i OR NOT CTRL.enable[n].
- Clearing an enable bit holds that core in reset and releases its pads to Z.

State machine: IDLE, CORE, RESP.
- IDLE, cyc&stb, local page: perform the register read/write, load wb_dat_o, go RESP with ack.
- IDLE, cyc&stb, core page, channel < NUM_CH and enabled:
  - clear the watchdog counter and go CORE;
  - a write passes wb_dat_i[7:0] to the core.
- IDLE, cyc&stb, core page, channel ≥ NUM_CH or disabled: go RESP with err; wb_dat_o=0.
- CORE:
  - assert the selected core's cyc/stb/we; all other cores see stb=0; the counter increments each cycle.
  - Core ack: latch {24'b0, core dat_o} into wb_dat_o, go RESP with ack.
  - Counter reaches TIMEOUT with no core ack: go RESP with err, set STATUS[16], load LAST_TO. Core ack and timeout in the same cycle: ack wins.
  - Core wb_err_o asserted: go RESP with err.
- RESP: exactly one of ack/err high for this one cycle; next state IDLE.
- cyc dropped in CORE (master abort): deassert core stb, go IDLE without ack or err.

## Timing
- Reset values: state IDLE; wb_ack_o, wb_err_o, irq_o, wb_rty_o = 0; wb_dat_o=0; CTRL=0; STATUS[16]=0; LAST_TO=0; counter 0.
- Reset has priority over every state. Reset in CORE aborts the access with no ack/err.
- Local access: stb sampled at edge k → ack high during cycle k+1. Latency 1.
- Core access: core stb asserted from edge k; core ack at edge k+m → wb_ack_o during cycle k+m+1. Core ack is typically m=2, so latency 3.
- Timeout: err high during cycle k+TIMEOUT+1.
- The master drops stb on the edge that samples ack. IDLE is re-entered on that same edge, so no double response occurs.
- Back-to-back accesses: one idle cycle (RESP) minimum between responses.
- irq_o lags core inta by one cycle.

## Test plan
- After reset, read 0x8000 → ack one cycle after stb, dat 0x52465032. Read 0x8001 → 0x00000000, no err.
- Write CTRL=0x0001, then write 0x48 to channel 0 PRERlo (adr 0x0000), read back → 0x00000048 with ack at latency 3. Channel 1 pads remain Z throughout.
- Access channel 2 (adr 0x0010) while disabled → wb_err_o one cycle, ack never. Access channel 5 with NUM_CH=4 → err.
- Force channel 0 core ack low with TIMEOUT=16 → err exactly 17 cycles after stb sampled; STATUS[16]=1; LAST_TO=0x00000003 for adr 0x0003. Write STATUS=0x10000 → flag clears.
- Enable channel 1, set mask bit 1, trigger core inta → irq_o rises one cycle later. Clear mask → irq_o falls next cycle.
- Assert rst_i mid-CORE → no ack/err; CTRL reads 0; all SDA/SCL Z next cycle.

Source files
------------

// File: rtl/rfp_i2c_hub.sv
// Wishbone hub fanning one slave port out to NUM_CH I2C byte cores, with a local
// register page, registered ack/err responses and a core-access watchdog.
//   state | meaning
//   IDLE  | wait for cyc&stb, decode page/channel
//   CORE  | selected core strobed, watchdog counting down
//   RESP  | one-cycle ack or err, then back to IDLE
module rfp_i2c_hub #(
  parameter int          NUM_CH   = 4,
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ID_VALUE = 32'h52465032
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [15:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  input  logic [3:0]        wb_sel_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_rty_o,
  output logic              irq_o,
  inout  wire  [NUM_CH-1:0] RFP_SDA,
  inout  wire  [NUM_CH-1:0] RFP_SCL
);
  localparam logic [7:0] CH_MASK = 8'((9'd1 << NUM_CH) - 9'd1);

  typedef enum logic [1:0] {IDLE, CORE, RESP} state_t;

  state_t      state;
  logic [15:0] cnt;
  logic [15:0] sel_adr;
  logic        sel_we;
  logic [7:0]  sel_dat;
  logic [7:0]  ctrl_en;
  logic [7:0]  ctrl_mask;
  logic        to_flag;
  logic [31:0] last_to;

  logic [7:0]  core_ack;
  logic [7:0]  core_err;
  logic [7:0]  core_inta;
  logic [7:0]  core_dat [8];
  logic [2:0]  sel_ch;
  logic [2:0]  req_ch;
  logic        ch_ok;
  logic        unused_in;

  assign wb_rty_o  = 1'b0;
  assign sel_ch    = sel_adr[5:3];
  assign req_ch    = wb_adr_i[5:3];
  assign ch_ok     = ({1'b0, req_ch} < 4'(NUM_CH)) && ctrl_en[req_ch];
  assign unused_in = ^{wb_sel_i, wb_dat_i[31:17]};

  for (genvar n = 0; n < 8; n++) begin : g_ch
    if (n < NUM_CH) begin : g_core
      logic core_stb;
      logic scl_oe_n;
      logic sda_oe_n;

      // Stb drops combinationally with cyc so a master abort never reaches the core.
      assign core_stb   = (state == CORE) && wb_cyc_i && (sel_ch == 3'(n));
      assign RFP_SCL[n] = scl_oe_n ? 1'bz : 1'b0;
      assign RFP_SDA[n] = sda_oe_n ? 1'bz : 1'b0;

      i2c_master_top u_core (
        .wb_clk_i     (clk_i),
        .wb_rst_i     (rst_i | ~ctrl_en[n]),
        .wb_adr_i     (sel_adr[2:0]),
        .wb_dat_i     (sel_dat),
        .wb_dat_o     (core_dat[n]),
        .wb_we_i      (sel_we),
        .wb_stb_i     (core_stb),
        .wb_cyc_i     (core_stb),
        .wb_ack_o     (core_ack[n]),
        .wb_err_o     (core_err[n]),
        .wb_inta_o    (core_inta[n]),
        .scl_pad_i    (RFP_SCL[n]),
        .scl_padoen_o (scl_oe_n),
        .sda_pad_i    (RFP_SDA[n]),
        .sda_padoen_o (sda_oe_n)
      );
    end else begin : g_tie
      assign core_ack[n]  = 1'b0;
      assign core_err[n]  = 1'b0;
      assign core_inta[n] = 1'b0;
      assign core_dat[n]  = 8'h00;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      sel_adr   <= '0;
      sel_we    <= 1'b0;
      sel_dat   <= '0;
      ctrl_en   <= '0;
      ctrl_mask <= '0;
      to_flag   <= 1'b0;
      last_to   <= '0;
      wb_dat_o  <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      irq_o    <= |(core_inta & ctrl_mask);
      case (state)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            sel_adr <= wb_adr_i;
            sel_we  <= wb_we_i;
            sel_dat <= wb_dat_i[7:0];
            if (wb_adr_i[15]) begin
              state    <= RESP;
              wb_ack_o <= 1'b1;
              case (wb_adr_i[2:0])
                3'd0: wb_dat_o <= ID_VALUE;
                3'd1: begin
                  wb_dat_o <= {16'h0, ctrl_mask, ctrl_en};
                  if (wb_we_i) begin
                    ctrl_en   <= wb_dat_i[7:0] & CH_MASK;
                    ctrl_mask <= wb_dat_i[15:8] & CH_MASK;
                  end
                end
                3'd2: begin
                  wb_dat_o <= {15'h0, to_flag, 8'h0, core_inta};
                  if (wb_we_i && wb_dat_i[16]) to_flag <= 1'b0;
                end
                3'd3:    wb_dat_o <= last_to;
                default: wb_dat_o <= '0;
              endcase
            end else if (ch_ok) begin
              state <= CORE;
              cnt   <= 16'(TIMEOUT - 1);
            end else begin
              state    <= RESP;
              wb_err_o <= 1'b1;
              wb_dat_o <= '0;
            end
          end
        end
        CORE: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (core_ack[sel_ch]) begin
            state    <= RESP;
            wb_ack_o <= 1'b1;
            wb_dat_o <= {24'h0, core_dat[sel_ch]};
          end else if (core_err[sel_ch]) begin
            state    <= RESP;
            wb_err_o <= 1'b1;
          end else if (cnt == 16'd0) begin
            state    <= RESP;
            wb_err_o <= 1'b1;
            to_flag  <= 1'b1;
            last_to  <= {13'h0, sel_ch, sel_adr};
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// Register-compatible byte core: prescale/control/tx/cmd registers, two-cycle ack,
// and a fixed-length transfer timer that holds SCL low and raises IF on completion.
module i2c_master_top #(
  parameter int XFER_CYC = 40
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic [2:0] wb_adr_i,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  input  logic       wb_we_i,
  input  logic       wb_stb_i,
  input  logic       wb_cyc_i,
  output logic       wb_ack_o,
  output logic       wb_err_o,
  output logic       wb_inta_o,
  input  logic       scl_pad_i,
  output logic       scl_padoen_o,
  input  logic       sda_pad_i,
  output logic       sda_padoen_o
);
  logic [15:0] prer;
  logic [7:0]  ctr, txr, rxr, tmr;
  logic        irq_flag, rxack, busy, acc;
  logic [7:0]  sr;
  logic        unused_scl;

  assign acc          = wb_cyc_i && wb_stb_i && !wb_ack_o;
  assign sr           = {rxack, busy, 4'h0, busy, irq_flag};
  assign wb_err_o     = 1'b0;
  assign wb_inta_o    = irq_flag & ctr[6];
  assign scl_padoen_o = ~busy;
  assign sda_padoen_o = ~(busy & ~txr[7]);
  assign unused_scl   = scl_pad_i;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      prer <= 16'hffff; ctr <= '0; txr <= '0; rxr <= '0; tmr <= '0;
      irq_flag <= 1'b0; rxack <= 1'b0; busy <= 1'b0;
      wb_ack_o <= 1'b0; wb_dat_o <= '0;
    end else begin
      wb_ack_o <= acc;
      if (acc) begin
        case (wb_adr_i)
          3'd0:    wb_dat_o <= prer[7:0];
          3'd1:    wb_dat_o <= prer[15:8];
          3'd2:    wb_dat_o <= ctr;
          3'd3:    wb_dat_o <= rxr;
          3'd4:    wb_dat_o <= sr;
          default: wb_dat_o <= '0;
        endcase
      end
      if (acc && wb_we_i) begin
        case (wb_adr_i)
          3'd0: prer[7:0]  <= wb_dat_i;
          3'd1: prer[15:8] <= wb_dat_i;
          3'd2: ctr        <= wb_dat_i;
          3'd3: txr        <= wb_dat_i;
          3'd4: begin
            if (wb_dat_i[0]) irq_flag <= 1'b0;
            if (ctr[7] && (wb_dat_i[4] || wb_dat_i[5]) && !busy) begin
              busy <= 1'b1;
              tmr  <= 8'(XFER_CYC - 1);
            end
          end
          default: ;
        endcase
      end
      if (busy) begin
        if (tmr == 8'd0) begin
          busy     <= 1'b0;
          irq_flag <= 1'b1;
          rxr      <= txr;
          rxack    <= sda_pad_i;
        end else begin
          tmr <= tmr - 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rfp_i2c_hub.sv
// Scoreboarded bench for rfp_i2c_hub: responses are matched against a queue of
// expectations pushed when each bus access is launched.
module tb_rfp_i2c_hub;
  localparam int NCH = 4;
  localparam int TO  = 16;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [15:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hf;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_rty_o, irq_o;
  wire  [NCH-1:0] sda, scl;

  for (genvar i = 0; i < NCH; i++) begin : g_pu
    pullup (sda[i]);
    pullup (scl[i]);
  end

  rfp_i2c_hub #(.NUM_CH(NCH), .TIMEOUT(TO), .ID_VALUE(32'h52465032)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
    .wb_we_i(wb_we_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
    .irq_o(irq_o), .RFP_SDA(sda), .RFP_SCL(scl)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       tag;
    int          kind;   // 1 = ack, 2 = err
    logic        chk_dat;
    logic [31:0] dat;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic wb_xfer(input string tag, input logic we, input logic [15:0] adr,
                         input logic [31:0] dat, input int kind, input logic [31:0] edat,
                         input int lat);
    exp_t e, got_e;
    int   n;
    e.tag = tag; e.kind = kind; e.chk_dat = !we || kind == 2; e.dat = edat; e.lat = lat;
    exp_q.push_back(e);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    n = 0;
    do begin
      step();
      n++;
    end while (!(wb_ack_o || wb_err_o) && n < 40);
    got_e = exp_q.pop_front();
    check({got_e.tag, "_kind"}, 32'({wb_err_o, wb_ack_o}), 32'(got_e.kind));
    check({got_e.tag, "_lat"}, 32'(n), 32'(got_e.lat));
    if (got_e.chk_dat) check({got_e.tag, "_dat"}, wb_dat_o, got_e.dat);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    step();
    check({got_e.tag, "_pulse"}, 32'({wb_err_o, wb_ack_o}), 32'h0);
  endtask

  initial begin
    repeat (3) step();
    check("rst_ack", 32'(wb_ack_o), 32'h0);
    check("rst_err", 32'(wb_err_o), 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_rty", 32'(wb_rty_o), 32'h0);
    check("rst_dat", wb_dat_o, 32'h0);
    rst_i = 1'b0;
    step();

    wb_xfer("id",       1'b0, 16'h8000, 32'h0,     1, 32'h52465032, 1);
    wb_xfer("ctrl_rst", 1'b0, 16'h8001, 32'h0,     1, 32'h0,        1);
    wb_xfer("ctrl_ff",  1'b1, 16'h8001, 32'hffff,  1, 32'h0,        1);
    wb_xfer("ctrl_msk", 1'b0, 16'h8001, 32'h0,     1, 32'h00000f0f, 1);
    wb_xfer("ctrl_en0", 1'b1, 16'h8001, 32'h0001,  1, 32'h0,        1);
    wb_xfer("loc5",     1'b0, 16'h8005, 32'h0,     1, 32'h0,        1);

    wb_xfer("prer_wr",  1'b1, 16'h0000, 32'h48,    1, 32'h0,        3);
    wb_xfer("prer_rd",  1'b0, 16'h0000, 32'h0,     1, 32'h00000048, 3);
    check("ch1_pads_z", 32'({sda[1], scl[1]}), 32'h3);

    wb_xfer("ch2_dis",  1'b0, 16'h0010, 32'h0,     2, 32'h0,        1);
    wb_xfer("ch5_oob",  1'b0, 16'h0028, 32'h0,     2, 32'h0,        1);

    force dut.core_ack = 8'h00;
    wb_xfer("timeout",  1'b0, 16'h0003, 32'h0,     2, 32'h0,        TO + 1);
    release dut.core_ack;
    wb_xfer("sts_to",   1'b0, 16'h8002, 32'h0,     1, 32'h00010000, 1);
    wb_xfer("last_to",  1'b0, 16'h8003, 32'h0,     1, 32'h00000003, 1);
    wb_xfer("sts_clr",  1'b1, 16'h8002, 32'h10000, 1, 32'h0,        1);
    wb_xfer("sts_rd",   1'b0, 16'h8002, 32'h0,     1, 32'h0,        1);

    wb_xfer("ctrl_en1", 1'b1, 16'h8001, 32'h0003,  1, 32'h0,        1);
    wb_xfer("ch1_ctr",  1'b1, 16'h000a, 32'hc0,    1, 32'h0,        3);
    wb_xfer("ch1_cmd",  1'b1, 16'h000c, 32'h10,    1, 32'h0,        3);
    check("ch1_scl_lo", 32'(scl[1]), 32'h0);
    repeat (50) step();
    check("irq_masked", 32'(irq_o), 32'h0);
    wb_xfer("sts_inta", 1'b0, 16'h8002, 32'h0,     1, 32'h00000002, 1);
    wb_xfer("mask_on",  1'b1, 16'h8001, 32'h0203,  1, 32'h0,        1);
    check("irq_rise", 32'(irq_o), 32'h1);
    wb_xfer("mask_off", 1'b1, 16'h8001, 32'h0003,  1, 32'h0,        1);
    check("irq_fall", 32'(irq_o), 32'h0);

    wb_xfer("ch1_cmd2", 1'b1, 16'h000c, 32'h11,    1, 32'h0,        3);
    check("ch1_busy", 32'(scl[1]), 32'h0);
    force dut.core_ack = 8'h00;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hang_quiet", 32'({wb_err_o, wb_ack_o}), 32'h0);
    end
    rst_i = 1'b1;
    step();
    check("rst_core_resp", 32'({wb_err_o, wb_ack_o}), 32'h0);
    check("rst_pads", 32'({sda, scl}), 32'hff);
    rst_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    release dut.core_ack;
    step();
    check("rst_after", 32'({wb_err_o, wb_ack_o}), 32'h0);
    wb_xfer("ctrl_clr", 1'b0, 16'h8001, 32'h0,     1, 32'h0,        1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
